// File: rtl/shift_cmd_sequencer.sv
// shift_cmd_sequencer
// Queues shift-register commands in a small FIFO and issues them one per
// cycle-run to a downstream universal shift register. Each command runs
// count+1 issue cycles; consecutive commands issue with no bubble.
// A local shadow register tracks what the downstream register holds.
//
// Ports:
//   clk, rst        : rising-edge clock, synchronous active-high reset
//   cmd_valid/ready : command handshake (ready depends only on FIFO level)
//   cmd_mode        : 00 hold, 01 shift right, 10 shift left, 11 load
//   cmd_count       : repeat count, command runs cmd_count+1 cycles
//   cmd_data        : parallel load value
//   cmd_sin         : serial-in bit for shift modes
//   sr_en, sel, par_out, sin : registered controls to downstream register
//   done            : high on the last issue cycle of each command
//   fifo_level      : current FIFO occupancy
//   shadow_q        : model of downstream register contents
module shift_cmd_sequencer #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          cmd_valid,
  output logic                          cmd_ready,
  input  logic [1:0]                    cmd_mode,
  input  logic [3:0]                    cmd_count,
  input  logic [3:0]                    cmd_data,
  input  logic                          cmd_sin,
  output logic                          sr_en,
  output logic [1:0]                    sel,
  output logic [3:0]                    par_out,
  output logic                          sin,
  output logic                          done,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic [3:0]                    shadow_q
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  typedef struct packed {
    logic [1:0] mode;
    logic [3:0] count;
    logic [3:0] data;
    logic       sin;
  } cmd_t;

  cmd_t            mem_q [FIFO_DEPTH];
  cmd_t            cmd_in;
  cmd_t            head;

  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]   level_q, level_d;
  state_t          state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;
  logic            sr_en_q, sr_en_d;
  logic [1:0]      sel_q, sel_d;
  logic [3:0]      par_q, par_d;
  logic            sin_q, sin_d;
  logic            done_q, done_d;
  logic [3:0]      shadow_d;
  logic            push, pop;

  assign cmd_in     = '{mode: cmd_mode, count: cmd_count, data: cmd_data, sin: cmd_sin};
  // Full blocks acceptance even when a pop happens in the same cycle.
  assign cmd_ready  = (level_q != LW'(FIFO_DEPTH));
  assign sr_en      = sr_en_q;
  assign sel        = sel_q;
  assign par_out    = par_q;
  assign sin        = sin_q;
  assign done       = done_q;
  assign fifo_level = level_q;

  always_comb begin
    head     = mem_q[rd_ptr_q];
    push     = cmd_valid && cmd_ready && !rst;
    // Pop whenever idle, or at the end of the last issue cycle, so the next
    // command follows with no bubble. Pushes land in the FIFO first (no bypass).
    pop      = ((state_q == IDLE) || (cnt_q == 4'd0)) && (level_q != '0);

    state_d  = IDLE;
    sr_en_d  = 1'b0;
    sel_d    = 2'b00;
    par_d    = 4'b0000;
    sin_d    = 1'b0;
    done_d   = 1'b0;
    cnt_d    = 4'd0;
    shadow_d = shadow_q;

    if (state_q == RUN) begin
      case (sel_q)
        2'b11:   shadow_d = par_q;
        2'b01:   shadow_d = {sin_q, shadow_q[3:1]};
        2'b10:   shadow_d = {shadow_q[2:0], sin_q};
        default: shadow_d = shadow_q;
      endcase
    end

    if (pop) begin
      state_d = RUN;
      sr_en_d = 1'b1;
      sel_d   = head.mode;
      par_d   = head.data;
      sin_d   = head.sin;
      cnt_d   = head.count;
      done_d  = (head.count == 4'd0);
    end else if ((state_q == RUN) && (cnt_q != 4'd0)) begin
      state_d = RUN;
      sr_en_d = 1'b1;
      sel_d   = sel_q;
      par_d   = par_q;
      sin_d   = sin_q;
      cnt_d   = cnt_q - 4'd1;
      done_d  = (cnt_q == 4'd1);
    end

    wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    level_d  = level_q + LW'(push) - LW'(pop);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      cnt_q    <= 4'd0;
      sr_en_q  <= 1'b0;
      sel_q    <= 2'b00;
      par_q    <= 4'b0000;
      sin_q    <= 1'b0;
      done_q   <= 1'b0;
      shadow_q <= 4'b0000;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      cnt_q    <= cnt_d;
      sr_en_q  <= sr_en_d;
      sel_q    <= sel_d;
      par_q    <= par_d;
      sin_q    <= sin_d;
      done_q   <= done_d;
      shadow_q <= shadow_d;
    end
  end

  // Command storage holds data only; occupancy is tracked by the pointers.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= cmd_in;
  end

endmodule

// File: tb/tb_shift_cmd_sequencer.sv
module tb_shift_cmd_sequencer;

  localparam int DEPTH = 4;

  typedef struct packed {
    logic [1:0] mode;
    logic [3:0] count;
    logic [3:0] data;
    logic       sin;
  } tcmd_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [1:0] cmd_mode = 2'b00;
  logic [3:0] cmd_count = 4'd0;
  logic [3:0] cmd_data = 4'd0;
  logic       cmd_sin = 1'b0;
  logic       sr_en;
  logic [1:0] sel;
  logic [3:0] par_out;
  logic       sin;
  logic       done;
  logic [2:0] fifo_level;
  logic [3:0] shadow_q;

  int total = 0;
  int bad = 0;

  // Reference model: a queue of pending commands, the command currently
  // issuing, and how many issue cycles it still has after the current one.
  tcmd_t      q[$];
  bit         m_active = 0;
  tcmd_t      m_cur;
  int         m_left = 0;
  logic [3:0] m_shadow = 4'b0000;

  shift_cmd_sequencer #(.FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_mode(cmd_mode), .cmd_count(cmd_count), .cmd_data(cmd_data),
    .cmd_sin(cmd_sin), .sr_en(sr_en), .sel(sel), .par_out(par_out),
    .sin(sin), .done(done), .fifo_level(fifo_level), .shadow_q(shadow_q)
  );

  always #5 clk = ~clk;

  function automatic logic [16:0] obs_vec();
    return {cmd_ready, sr_en, sel, par_out, sin, done, fifo_level, shadow_q};
  endfunction

  function automatic logic [16:0] exp_vec();
    logic [1:0] s;
    logic [3:0] p;
    logic       b;
    s = m_active ? m_cur.mode : 2'b00;
    p = m_active ? m_cur.data : 4'b0000;
    b = m_active ? m_cur.sin  : 1'b0;
    return {(q.size() != DEPTH), m_active, s, p, b, (m_active && m_left == 0),
            3'(q.size()), m_shadow};
  endfunction

  task automatic model_edge();
    bit acc;
    tcmd_t c;
    if (rst) begin
      q.delete();
      m_active = 0;
      m_left = 0;
      m_shadow = 4'b0000;
      return;
    end
    acc = cmd_valid && (q.size() < DEPTH);
    if (m_active) begin
      case (m_cur.mode)
        2'b11: m_shadow = m_cur.data;
        2'b01: m_shadow = {m_cur.sin, m_shadow[3:1]};
        2'b10: m_shadow = {m_shadow[2:0], m_cur.sin};
        default: ;
      endcase
    end
    if (!m_active || m_left == 0) begin
      if (q.size() > 0) begin
        m_cur = q.pop_front();
        m_left = int'(m_cur.count);
        m_active = 1;
      end else begin
        m_active = 0;
      end
    end else begin
      m_left--;
    end
    if (acc) begin
      c = '{mode: cmd_mode, count: cmd_count, data: cmd_data, sin: cmd_sin};
      q.push_back(c);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic drive(input bit v, input logic [1:0] m, input logic [3:0] cnt,
                       input logic [3:0] d, input logic s);
    cmd_valid = v;
    cmd_mode  = m;
    cmd_count = cnt;
    cmd_data  = d;
    cmd_sin   = s;
  endtask

  task automatic drain(input string name);
    int n = 0;
    drive(0, 0, 0, 0, 0);
    while ((m_active || q.size() != 0) && n < 200) begin
      tick();
      n++;
      total++;
      if (obs_vec() !== exp_vec()) begin
        bad++;
        $display("FAIL %s_drain cyc=%0d got=%h exp=%h", name, n, obs_vec(), exp_vec());
      end
    end
    total++;
    if (n >= 200) begin
      bad++;
      $display("FAIL %s_drain_timeout got=%0d exp<200", name, n);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(1, 2'b11, 4'd0, 4'hF, 1);
    repeat (3) tick();
    total++;
    if ({cmd_ready, sr_en, sel, par_out, sin, done, fifo_level, shadow_q} !== 17'b1_0_00_0000_0_0_000_0000) begin
      bad++;
      $display("FAIL reset_state got=%h exp=%h", obs_vec(), 17'b1_0_00_0000_0_0_000_0000);
    end
    drive(0, 0, 0, 0, 0);
    rst = 1'b0;
    tick();
    total++;
    if (fifo_level !== 3'd0 || sr_en !== 1'b0) begin
      bad++;
      $display("FAIL reset_no_accept got_level=%0d got_sr_en=%b exp=0/0", fifo_level, sr_en);
    end
  endtask

  task automatic test_single_load();
    int en_cnt = 0;
    drive(1, 2'b11, 4'd0, 4'b1010, 0);
    for (int i = 0; i < 5; i++) begin
      tick();
      if (i == 0) drive(0, 0, 0, 0, 0);
      en_cnt += int'(sr_en);
      total++;
      if (obs_vec() !== exp_vec()) begin
        bad++;
        $display("FAIL single_load cyc=%0d got=%h exp=%h", i, obs_vec(), exp_vec());
      end
      if (i == 1) begin
        total++;
        if ({sr_en, sel, par_out, done} !== 8'b1_11_1010_1) begin
          bad++;
          $display("FAIL single_load_issue got=%b exp=%b", {sr_en, sel, par_out, done}, 8'b1_11_1010_1);
        end
      end
    end
    total++;
    if (shadow_q !== 4'b1010 || en_cnt != 1) begin
      bad++;
      $display("FAIL single_load_result got=%b/%0d exp=1010/1", shadow_q, en_cnt);
    end
  endtask

  task automatic test_shift_run();
    logic [3:0] seen [$];
    drive(1, 2'b01, 4'd2, 4'd0, 1);
    for (int i = 0; i < 6; i++) begin
      tick();
      if (i == 0) drive(0, 0, 0, 0, 0);
      if (i >= 2 && i <= 4) seen.push_back(shadow_q);
      total++;
      if (obs_vec() !== exp_vec()) begin
        bad++;
        $display("FAIL shift_run cyc=%0d got=%h exp=%h", i, obs_vec(), exp_vec());
      end
    end
    total++;
    if (seen.size() != 3 || seen[0] !== 4'b1101 || seen[1] !== 4'b1110 || seen[2] !== 4'b1111) begin
      bad++;
      $display("FAIL shift_run_seq got=%b,%b,%b exp=1101,1110,1111", seen[0], seen[1], seen[2]);
    end
  endtask

  task automatic test_back_to_back();
    logic [5:0] en_hist = '0;
    logic [5:0] dn_hist = '0;
    drive(1, 2'b10, 4'd1, 4'd0, 0);
    for (int i = 0; i < 6; i++) begin
      tick();
      if (i == 0) drive(1, 2'b11, 4'd0, 4'b0110, 0);
      if (i == 1) drive(0, 0, 0, 0, 0);
      en_hist[i] = sr_en;
      dn_hist[i] = done;
      total++;
      if (obs_vec() !== exp_vec()) begin
        bad++;
        $display("FAIL back_to_back cyc=%0d got=%h exp=%h", i, obs_vec(), exp_vec());
      end
    end
    total++;
    if (en_hist !== 6'b001110 || dn_hist !== 6'b001100 || shadow_q !== 4'b0110) begin
      bad++;
      $display("FAIL back_to_back_shape got=%b/%b/%b exp=001110/001100/0110", en_hist, dn_hist, shadow_q);
    end
  endtask

  task automatic test_full();
    drive(1, 2'b00, 4'd15, 4'd0, 0);
    for (int i = 0; i < 26; i++) begin
      tick();
      if (i == 0) drive(1, 2'b11, 4'(i + 1), 4'(i + 3), 1);
      if (i >= 1 && i <= 4) drive(1, 2'b11, 4'd0, 4'(i + 3), 1);
      if (i == 6) drive(0, 0, 0, 0, 0);
      total++;
      if (obs_vec() !== exp_vec()) begin
        bad++;
        $display("FAIL full cyc=%0d got=%h exp=%h", i, obs_vec(), exp_vec());
      end
      if (i == 5) begin
        total++;
        if (cmd_ready !== 1'b0 || fifo_level !== 3'd4) begin
          bad++;
          $display("FAIL full_state got=%b/%0d exp=0/4", cmd_ready, fifo_level);
        end
      end
      if (i == 6) begin
        total++;
        if (fifo_level !== 3'd4) begin
          bad++;
          $display("FAIL full_reject got=%0d exp=4", fifo_level);
        end
      end
      if (i == 17) begin
        total++;
        if (cmd_ready !== 1'b1 || fifo_level !== 3'd3) begin
          bad++;
          $display("FAIL full_release got=%b/%0d exp=1/3", cmd_ready, fifo_level);
        end
      end
    end
    drain("full");
  endtask

  task automatic test_reset_mid_run();
    bit saw_done = 0;
    drive(1, 2'b01, 4'd15, 4'd0, 1);
    for (int i = 0; i < 5; i++) begin
      tick();
      if (i == 0) drive(1, 2'b11, 4'd0, 4'd5, 0);
      if (i == 2) drive(0, 0, 0, 0, 0);
      saw_done |= done;
      total++;
      if (obs_vec() !== exp_vec()) begin
        bad++;
        $display("FAIL rst_mid cyc=%0d got=%h exp=%h", i, obs_vec(), exp_vec());
      end
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    saw_done |= done;
    total++;
    if (sr_en !== 1'b0 || fifo_level !== 3'd0 || shadow_q !== 4'b0000 || saw_done) begin
      bad++;
      $display("FAIL rst_mid_abort got=%b/%0d/%b/%b exp=0/0/0000/0", sr_en, fifo_level, shadow_q, saw_done);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      total++;
      if (obs_vec() !== exp_vec() || done !== 1'b0) begin
        bad++;
        $display("FAIL rst_mid_after cyc=%0d got=%h exp=%h", i, obs_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_hold();
    int en_cnt = 0;
    logic [3:0] start;
    drive(1, 2'b11, 4'd0, 4'b1001, 0);
    tick();
    drive(0, 0, 0, 0, 0);
    tick();
    tick();
    start = m_shadow;
    drive(1, 2'b00, 4'd3, 4'b0110, 1);
    for (int i = 0; i < 7; i++) begin
      tick();
      if (i == 0) drive(0, 0, 0, 0, 0);
      en_cnt += int'(sr_en);
      total++;
      if (obs_vec() !== exp_vec() || shadow_q !== 4'b1001) begin
        bad++;
        $display("FAIL hold cyc=%0d got=%h exp=%h start=%b", i, obs_vec(), exp_vec(), start);
      end
    end
    total++;
    if (en_cnt != 4) begin
      bad++;
      $display("FAIL hold_len got=%0d exp=4", en_cnt);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      rst = ($urandom_range(0, 60) == 0);
      drive($urandom_range(0, 2) != 0, 2'($urandom), 4'($urandom_range(0, 15) < 12 ? $urandom_range(0, 3) : $urandom_range(0, 15)),
            4'($urandom), 1'($urandom));
      tick();
      total++;
      if (obs_vec() !== exp_vec()) begin
        bad++;
        $display("FAIL random cyc=%0d got=%h exp=%h", i, obs_vec(), exp_vec());
      end
    end
    rst = 1'b0;
    drain("random");
  endtask

  initial begin
    test_reset();
    test_single_load();
    test_shift_run();
    test_back_to_back();
    test_full();
    test_reset_mid_run();
    test_hold();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
